// File: rtl/serial_subt_pkg.sv
// Shared types and sizing helpers for the
// bit-serial subtractor controller.
package serial_subt_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  function automatic int cnt_width(input int w);
    return (w > 2) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/full_subt.sv
// One-bit full subtractor built from two
// half-subtractor stages.
module full_subt (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  logic d1;
  logic b1;
  logic b2;

  assign d1   = x ^ y;
  assign b1   = ~x & y;
  assign d    = d1 ^ bin;
  assign b2   = ~d1 & bin;
  assign bout = b1 | b2;

endmodule

// File: rtl/serial_subtractor_ctrl.sv
// Sequencer computing a - b LSB-first through
// a single full_subt cell, one bit per clock.
module serial_subtractor_ctrl
  import serial_subt_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             brw_q, brw_d;
  logic             bout_q, bout_d;

  logic cell_d;
  logic cell_b;

  full_subt u_cell (
    .x    (a_sh_q[0]),
    .y    (b_sh_q[0]),
    .bin  (brw_q),
    .d    (cell_d),
    .bout (cell_b)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    res_d   = res_q;
    diff_d  = diff_q;
    brw_d   = brw_q;
    bout_d  = bout_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SHIFT;
          a_sh_d  = a;
          b_sh_d  = b;
          res_d   = '0;
          cnt_d   = '0;
          brw_d   = 1'b0;
        end
      end
      SHIFT: begin
        a_sh_d = a_sh_q >> 1;
        b_sh_d = b_sh_q >> 1;
        res_d  = {cell_d, res_q[WIDTH-1:1]};
        brw_d  = cell_b;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_d = DONE;
          diff_d  = res_d;
          bout_d  = cell_b;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      res_q   <= '0;
      diff_q  <= '0;
      brw_q   <= 1'b0;
      bout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      res_q   <= res_d;
      diff_q  <= diff_d;
      brw_q   <= brw_d;
      bout_q  <= bout_d;
    end
  end

  assign busy       = (state_q == SHIFT);
  assign done       = (state_q == DONE);
  assign diff       = diff_q;
  assign borrow_out = bout_q;

endmodule

// File: tb/tb_serial_subtractor_ctrl.sv
// Bench for serial_subtractor_ctrl: cycle model
// compare plus directed literal result checks.
module tb_serial_subtractor_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         borrow_out;

  int checks = 0;
  int errors = 0;
  int ndone  = 0;

  serial_subtractor_ctrl #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .a          (a),
    .b          (b),
    .busy       (busy),
    .done       (done),
    .diff       (diff),
    .borrow_out (borrow_out)
  );

  always #5 clk = ~clk;

  // Model: phase 0 idle, 1..W busy, W+1 done.
  int           m_phase = 0;
  logic [W-1:0] m_a = '0;
  logic [W-1:0] m_b = '0;
  logic [W-1:0] m_diff = '0;
  logic         m_bor = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase <= 0;
      m_diff  <= '0;
      m_bor   <= 1'b0;
    end else if (m_phase == 0) begin
      if (start) begin
        m_phase <= 1;
        m_a     <= a;
        m_b     <= b;
      end
    end else if (m_phase == W) begin
      m_phase <= W + 1;
      m_diff  <= W'(int'(m_a) - int'(m_b));
      m_bor   <= (m_a < m_b);
    end else if (m_phase == W + 1) begin
      m_phase <= 0;
    end else begin
      m_phase <= m_phase + 1;
    end
  end

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h @%0t",
               nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    check("busy", 32'(busy),
          32'(m_phase >= 1 && m_phase <= W));
    check("done", 32'(done), 32'(m_phase == W + 1));
    check("diff", 32'(diff), 32'(m_diff));
    check("borrow", 32'(borrow_out), 32'(m_bor));
    if (done === 1'b1) ndone++;
  end

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        ok = 1'b1;
        return;
      end
    end
    checks++;
    errors++;
    $display("FAIL done_timeout: got 0 expected 1 @%0t",
             $time);
  endtask

  task automatic pulse(input logic [W-1:0] av,
                       input logic [W-1:0] bv);
    @(negedge clk);
    start = 1'b1;
    a = av;
    b = bv;
    @(negedge clk);
    start = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
  endtask

  task automatic run_op(input string nm,
                        input logic [W-1:0] av,
                        input logic [W-1:0] bv,
                        input logic [W-1:0] ed,
                        input logic eb);
    bit ok;
    pulse(av, bv);
    wait_done(ok);
    if (ok) begin
      check({nm, "_diff"}, 32'(diff), 32'(ed));
      check({nm, "_bor"}, 32'(borrow_out), 32'(eb));
    end
  endtask

  initial begin
    bit  ok;
    time t0;
    time t1;
    int  n0;
    #1 rst = 1'b1;
    #1;
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_diff", 32'(diff), 32'h0);
    check("rst_bor", 32'(borrow_out), 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Busy window: 8 cycles, then done.
    pulse(8'h5A, 8'h3C);
    for (int i = 1; i < W; i++) begin
      check("win_busy", 32'(busy), 32'h1);
      @(negedge clk);
    end
    check("win_busy_last", 32'(busy), 32'h1);
    @(negedge clk);
    check("win_done", 32'(done), 32'h1);
    check("win_diff", 32'(diff), 32'h1E);
    check("win_bor", 32'(borrow_out), 32'h0);
    @(negedge clk);

    run_op("neg", 8'h03, 8'h05, 8'hFE, 1'b1);
    run_op("zero", 8'h00, 8'h00, 8'h00, 1'b0);
    run_op("max", 8'hFF, 8'h00, 8'hFF, 1'b0);
    run_op("under", 8'h00, 8'hFF, 8'h01, 1'b1);

    // Start held high: one result every W+2.
    @(negedge clk);
    start = 1'b1;
    a = 8'hFF;
    b = 8'h01;
    wait_done(ok);
    t0 = $time;
    for (int k = 0; k < 3; k++) begin
      wait_done(ok);
      t1 = $time;
      check("held_gap", 32'(t1 - t0), 32'd100);
      check("held_diff", 32'(diff), 32'hFE);
      check("held_bor", 32'(borrow_out), 32'h0);
      t0 = t1;
    end
    start = 1'b0;
    repeat (W + 3) @(negedge clk);

    // Start while busy is ignored.
    n0 = ndone;
    pulse(8'h10, 8'h01);
    @(negedge clk);
    start = 1'b1;
    a = 8'h00;
    b = 8'hFF;
    @(negedge clk);
    start = 1'b0;
    repeat (W + 8) @(negedge clk);
    check("ign_count", 32'(ndone - n0), 32'd1);
    check("ign_diff", 32'(diff), 32'h0F);
    check("ign_bor", 32'(borrow_out), 32'h0);

    // Reset mid-operation aborts.
    pulse(8'h80, 8'h01);
    repeat (3) @(negedge clk);
    n0 = ndone;
    rst = 1'b1;
    #1;
    check("abort_busy", 32'(busy), 32'h0);
    check("abort_done", 32'(done), 32'h0);
    check("abort_diff", 32'(diff), 32'h0);
    check("abort_bor", 32'(borrow_out), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    repeat (W + 4) @(negedge clk);
    check("abort_nodone", 32'(ndone - n0), 32'd0);
    check("abort_hold", 32'(diff), 32'h0);
    run_op("after", 8'h80, 8'h01, 8'h7F, 1'b0);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_subtractor_ctrl.md
# serial_subtractor_ctrl

Bit-serial N-bit subtractor controller. It accepts two unsigned operands on a start strobe and computes a − b LSB-first, one bit per clock, through a single full-subtractor cell. It reports the difference and the final borrow with a busy/done handshake. The block sits beside the existing combinational subtractor cells as the sequencing layer for area-constrained multi-bit subtraction.

## Interface
- WIDTH, default 8: operand/result width in bits; legal range ≥ 2.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  minuend; captured on the accepted start edge.
- b  input  WIDTH  subtrahend; captured on the accepted start edge.
- busy  output  1  high while an operation is in progress (SHIFT state).
- done  output  1  one-cycle pulse; marks diff/borrow_out newly valid.
- diff  output  WIDTH  result (a − b) mod 2^WIDTH; held until the next completion.
- borrow_out  output  1  final borrow; 1 ⇔ a < b unsigned.

## Operation
- Decided: one clock; reset is asynchronous and active-high. Ports are named clk and rst.
- States:
  - IDLE: reset state; waits for start.
  - SHIFT: processes one bit per cycle.
  - DONE: single-cycle completion state.
- IDLE → SHIFT when start = 1. On that edge:
  - a and b are latched into internal operand shift registers.
  - The bit counter is cleared to 0.
  - The internal borrow flop is cleared to 0.
- SHIFT, each cycle:
  - The full-subtractor cell takes inputs (a_sh[0], b_sh[0], borrow_q).
  - Its difference bit shifts into the MSB of the result shift register (right shift).
  - Its borrow output is written to borrow_q.
  - Both operand registers shift right by 1.
  - The counter increments.
- SHIFT → DONE on the edge that processes bit WIDTH−1 (counter == WIDTH−1). On that same edge, diff is loaded from the completed result and borrow_out from the final borrow.
- DONE → IDLE unconditionally on the next edge.
- start is ignored in SHIFT and DONE. No queuing; the requester must wait for busy = 0 and done = 0.
- The a and b inputs may change freely after the accepted start edge.
- Arithmetic: the cell computes diff = x ^ y ^ bin and bout = (~x & y) | (~(x ^ y) & bin). The counter is $clog2(WIDTH) bits wide; comparisons use WIDTH−1 only.

## Timing
- Reset values, applied immediately on rst assertion and regardless of the clock:
  - State = IDLE.
  - busy = 0, done = 0, diff = 0, borrow_out = 0.
  - Counter, borrow flop and shift registers = 0.
- Reset mid-operation aborts the operation. No done pulse follows, and diff retains its reset value of 0.
- Latency, with start accepted at edge k:
  - busy = 1 from after edge k until after edge k+WIDTH.
  - done = 1 between edges k+WIDTH and k+WIDTH+1.
  - Total latency is WIDTH+1 cycles from start to return to IDLE.
- The earliest next accept is edge k+WIDTH+2, i.e. start held high gives one operation every WIDTH+2 cycles.
- diff and borrow_out change only on the edge entering DONE; they are stable at all other times.
- busy and done are registered state decodes and are never high simultaneously.

## Structure
- Package serial_subt_pkg holds:
  - The state typedef (enum IDLE, SHIFT, DONE; 2 bits).
  - Localparam helpers for counter width.
- Sub-module full_subt (ports x, y, bin → d, bout) is the one combinational cell. It is built from two half-subtractor stages, with bout = borrow1 | borrow2.
- The top level contains the FSM, counter, operand and result shift registers, and output registers.

## Test plan
- WIDTH=8, a=0x5A, b=0x3C, start pulse → busy for 8 cycles; done pulse at cycle 9; diff=0x1E, borrow_out=0.
- a=0x03, b=0x05 → diff=0xFE, borrow_out=1. Then a=0x00, b=0x00 → diff=0x00, borrow_out=0 (borrow flop cleared between operations).
- a=0xFF, b=0x01 with start held high continuously → results 0xFE/0 repeat with done pulses exactly 10 cycles apart.
- Start pulse with a=0x10, b=0x01, followed by a second start with a=0x00, b=0xFF at cycle 3 while busy → second start ignored; diff=0x0F, borrow_out=0; exactly one done pulse.
- Assert rst at cycle 4 of an operation with a=0x80, b=0x01 → outputs immediately 0, state IDLE, no done pulse. Then a new start with a=0x80, b=0x01 → diff=0x7F, borrow_out=0.
